// File: rtl/axi_stream_extract_header.sv
// Strips an H-byte header from the front of each AXI-Stream packet. The header goes out on its
// own channel, right-aligned, and the payload is realigned to the MSBs of the output stream.
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    input  logic                    valid_remove,
    input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
    output logic                    ready_remove
);

    localparam int CW = BYTE_CNT_WD + 1;
    localparam logic [CW-1:0] BCNT = CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [CW-1:0]           res_cnt_q, res_cnt_d;
    logic                    valid_out_q, valid_out_d, last_out_q, last_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    valid_hdr_q, valid_hdr_d;
    logic [DATA_WD-1:0]      data_hdr_q, data_hdr_d;
    logic [DATA_BYTE_WD-1:0] keep_hdr_q, keep_hdr_d;
    logic                    active_q;

    logic [DATA_WD-1:0]      masked, hdr_data, first_res, st_data, st_res;
    logic [DATA_BYTE_WD-1:0] hdr_keep;
    logic [CW-1:0]           n_in, h, m, first_r, st_cnt, st_r;
    logic [CW:0]             sum;
    logic                    pay_free, hdr_free, accept, idle_ok;

    function automatic logic [DATA_BYTE_WD-1:0] msb_keep(input logic [CW-1:0] k);
        logic [DATA_BYTE_WD-1:0] r;
        for (int i = 0; i < DATA_BYTE_WD; i++) r[DATA_BYTE_WD-1-i] = (CW'(i) < k);
        return r;
    endfunction

    always_comb begin
        n_in   = '0;
        masked = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (keep_in[i]) begin
                n_in = n_in + CW'(1);
                masked[8*i +: 8] = data_in[8*i +: 8];
            end
        end
        h         = CW'(byte_remove_cnt) + CW'(1);
        m         = (n_in < h) ? n_in : h;
        hdr_data  = masked >> {BCNT - m, 3'b000};
        for (int i = 0; i < DATA_BYTE_WD; i++) hdr_keep[i] = (CW'(i) < m);
        first_res = masked << {h, 3'b000};
        first_r   = (n_in > h) ? n_in - h : '0;
        // Residual bytes sit at the top; new bytes slot in right behind them.
        sum       = {1'b0, res_cnt_q} + {1'b0, n_in};
        st_data   = res_q | (masked >> {res_cnt_q, 3'b000});
        st_cnt    = (sum > {1'b0, BCNT}) ? BCNT : sum[CW-1:0];
        st_res    = masked << {BCNT - res_cnt_q, 3'b000};
        st_r      = (sum > {1'b0, BCNT}) ? sum[CW-1:0] - BCNT : '0;
    end

    assign pay_free = !valid_out_q || ready_out;
    assign hdr_free = !valid_hdr_q || ready_header;
    assign idle_ok  = active_q && valid_remove && hdr_free && pay_free;

    always_comb begin
        ready_in     = 1'b0;
        ready_remove = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_in     = idle_ok;
                // Header length is consumed only together with the first beat.
                ready_remove = idle_ok && valid_in;
            end
            STREAM:  ready_in = pay_free;
            default: ready_in = 1'b0;
        endcase
    end

    assign accept = valid_in && ready_in;

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        valid_out_d = (valid_out_q && ready_out) ? 1'b0 : valid_out_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        valid_hdr_d = (valid_hdr_q && ready_header) ? 1'b0 : valid_hdr_q;
        data_hdr_d  = data_hdr_q;
        keep_hdr_d  = keep_hdr_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    valid_hdr_d = 1'b1;
                    data_hdr_d  = hdr_data;
                    keep_hdr_d  = hdr_keep;
                    if (!last_in) begin
                        state_d   = STREAM;
                        res_d     = first_res;
                        res_cnt_d = first_r;
                    end else begin
                        res_d     = '0;
                        res_cnt_d = '0;
                        if (first_r != '0) begin
                            valid_out_d = 1'b1;
                            data_out_d  = first_res;
                            keep_out_d  = msb_keep(first_r);
                            last_out_d  = 1'b1;
                        end
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    valid_out_d = 1'b1;
                    data_out_d  = st_data;
                    keep_out_d  = msb_keep(st_cnt);
                    last_out_d  = 1'b0;
                    res_d       = st_res;
                    res_cnt_d   = st_r;
                    if (last_in) begin
                        if (sum <= {1'b0, BCNT}) begin
                            last_out_d = 1'b1;
                            res_d      = '0;
                            res_cnt_d  = '0;
                            state_d    = IDLE;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            default: begin
                if (pay_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_q;
                    keep_out_d  = msb_keep(res_cnt_q);
                    last_out_d  = 1'b1;
                    res_d       = '0;
                    res_cnt_d   = '0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            res_q       <= '0;
            res_cnt_q   <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
            valid_hdr_q <= 1'b0;
            data_hdr_q  <= '0;
            keep_hdr_q  <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
            valid_hdr_q <= valid_hdr_d;
            data_hdr_q  <= data_hdr_d;
            keep_hdr_q  <= keep_hdr_d;
            active_q    <= 1'b1;
        end
    end

    assign valid_out    = valid_out_q;
    assign data_out     = data_out_q;
    assign keep_out     = keep_out_q;
    assign last_out     = last_out_q;
    assign valid_header = valid_hdr_q;
    assign data_header  = data_hdr_q;
    assign keep_header  = keep_hdr_q;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed bench for axi_stream_extract_header: packets with hand-computed header and payload
// beats, payload and header backpressure, and reset in the middle of a packet.
module tb_axi_stream_extract_header;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, last_in, ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, last_out, ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_header, ready_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;
    logic        valid_remove, ready_remove;
    logic [1:0]  byte_remove_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [36:0] pay_q[$];
    logic [35:0] hdr_q[$];

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out),
        .valid_header    (valid_header),
        .data_header     (data_header),
        .keep_header     (keep_header),
        .ready_header    (ready_header),
        .valid_remove    (valid_remove),
        .byte_remove_cnt (byte_remove_cnt),
        .ready_remove    (ready_remove)
    );

    always #5 clk = ~clk;

    // Inputs only change at posedge+1, so what is seen at negedge is what transfers next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out && ready_out) pay_q.push_back({data_out, keep_out, last_out});
            if (valid_header && ready_header) hdr_q.push_back({data_header, keep_header});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input string tag, input logic [31:0] d, input logic [3:0] k,
                        input logic l);
        int   n;
        logic got;
        valid_in     = 1'b1;
        data_in      = d;
        keep_in      = k;
        last_in      = l;
        valid_remove = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = ready_in;
            @(posedge clk);
            #1;
            n++;
        end
        valid_in     = 1'b0;
        valid_remove = 1'b0;
        data_in      = '0;
        keep_in      = '0;
        last_in      = 1'b0;
        chk({tag, "_accept"}, 64'(got), 64'd1);
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic chk_pay(input string tag, input logic [31:0] d, input logic [3:0] k,
                           input logic l);
        logic [36:0] v;
        v = '0;
        if (pay_q.size() > 0) v = pay_q.pop_front();
        chk(tag, 64'(v), 64'({d, k, l}));
    endtask

    task automatic chk_hdr(input string tag, input logic [31:0] d, input logic [3:0] k);
        logic [35:0] v;
        v = '0;
        if (hdr_q.size() > 0) v = hdr_q.pop_front();
        chk(tag, 64'(v), 64'({d, k}));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_pay_left"}, 64'(pay_q.size()), 64'd0);
        chk({tag, "_hdr_left"}, 64'(hdr_q.size()), 64'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        valid_in        = 1'b1;
        valid_remove    = 1'b1;
        data_in         = 32'hFFFF_FFFF;
        keep_in         = 4'hF;
        last_in         = 1'b0;
        byte_remove_cnt = 2'd1;
        ready_out       = 1'b1;
        ready_header    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", 64'({valid_out, valid_header, last_out, ready_in, ready_remove}), 64'd0);
        chk("rst_data", 64'({data_out, data_header}), 64'd0);
        chk("rst_keep", 64'({keep_out, keep_header}), 64'd0);
        valid_in     = 1'b0;
        valid_remove = 1'b0;
        data_in      = '0;
        keep_in      = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // H=2 three-beat packet ending in a flush beat
        byte_remove_cnt = 2'd1;
        send("a1", 32'hA1A2A3A4, 4'hF, 1'b0);
        send("a2", 32'hB1B2B3B4, 4'hF, 1'b0);
        send("a3", 32'hC1C2C300, 4'hE, 1'b1);
        drain();
        chk_hdr("a_hdr", 32'h0000A1A2, 4'h3);
        chk_pay("a_p0", 32'hA3A4B1B2, 4'hF, 1'b0);
        chk_pay("a_p1", 32'hB3B4C1C2, 4'hF, 1'b0);
        chk_pay("a_p2", 32'hC3000000, 4'h8, 1'b1);
        chk_empty("a");

        // H=4: the whole first beat is header
        byte_remove_cnt = 2'd3;
        send("b1", 32'h11223344, 4'hF, 1'b0);
        send("b2", 32'h55667788, 4'hC, 1'b1);
        drain();
        chk_hdr("b_hdr", 32'h11223344, 4'hF);
        chk_pay("b_p0", 32'h55660000, 4'hC, 1'b1);
        chk_empty("b");

        // H=2 single short beat fully consumed by the header, then H=1 single beat
        byte_remove_cnt = 2'd1;
        send("d1", 32'hAABB0000, 4'hC, 1'b1);
        byte_remove_cnt = 2'd0;
        send("c1", 32'hDEADBEEF, 4'hF, 1'b1);
        drain();
        chk_hdr("d_hdr", 32'h0000AABB, 4'h3);
        chk_hdr("c_hdr", 32'h000000DE, 4'h1);
        chk_pay("c_p0", 32'hADBEEF00, 4'hE, 1'b1);
        chk_empty("dc");

        // Payload backpressure in the middle of a packet
        byte_remove_cnt = 2'd1;
        ready_out = 1'b0;
        send("e1", 32'hA1A2A3A4, 4'hF, 1'b0);
        send("e2", 32'hB1B2B3B4, 4'hF, 1'b0);
        valid_in = 1'b1;
        data_in  = 32'hC1C2C300;
        keep_in  = 4'hE;
        last_in  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("e_stall_ready_in", 64'(ready_in), 64'd0);
            chk("e_stall_out", 64'({valid_out, data_out, keep_out, last_out}),
                64'({1'b1, 32'hA3A4B1B2, 4'hF, 1'b0}));
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        send("e3", 32'hC1C2C300, 4'hE, 1'b1);
        drain();
        chk_hdr("e_hdr", 32'h0000A1A2, 4'h3);
        chk_pay("e_p0", 32'hA3A4B1B2, 4'hF, 1'b0);
        chk_pay("e_p1", 32'hB3B4C1C2, 4'hF, 1'b0);
        chk_pay("e_p2", 32'hC3000000, 4'h8, 1'b1);
        chk_empty("e");

        // Header backpressure blocks the next packet's first beat
        ready_header    = 1'b0;
        byte_remove_cnt = 2'd0;
        send("f1", 32'hDEADBEEF, 4'hF, 1'b1);
        byte_remove_cnt = 2'd3;
        valid_in     = 1'b1;
        valid_remove = 1'b1;
        data_in      = 32'h11223344;
        keep_in      = 4'hF;
        last_in      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("f_block_ready", 64'({ready_in, ready_remove}), 64'd0);
            chk("f_hold_hdr", 64'({valid_header, data_header, keep_header}),
                64'({1'b1, 32'h000000DE, 4'h1}));
        end
        @(posedge clk);
        #1;
        ready_header = 1'b1;
        send("f2", 32'h11223344, 4'hF, 1'b0);
        send("f3", 32'h55667788, 4'hC, 1'b1);
        drain();
        chk_hdr("f_hdr0", 32'h000000DE, 4'h1);
        chk_hdr("f_hdr1", 32'h11223344, 4'hF);
        chk_pay("f_p0", 32'hADBEEF00, 4'hE, 1'b1);
        chk_pay("f_p1", 32'h55660000, 4'hC, 1'b1);
        chk_empty("f");

        // Reset after the second beat of a packet discards it
        byte_remove_cnt = 2'd1;
        send("g1", 32'hA1A2A3A4, 4'hF, 1'b0);
        send("g2", 32'hB1B2B3B4, 4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("g_rst_valids", 64'({valid_out, valid_header, last_out}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pay_q.delete();
        hdr_q.delete();
        @(posedge clk);
        #1;
        byte_remove_cnt = 2'd0;
        send("g3", 32'hDEADBEEF, 4'hF, 1'b1);
        drain();
        chk_hdr("g_hdr", 32'h000000DE, 4'h1);
        chk_pay("g_p0", 32'hADBEEF00, 4'hE, 1'b1);
        chk_empty("g");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
